// File: rtl/sys_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sys_array_sequencer
// Brief    : Runs one NxN matrix multiply C = A*B on the systolic PE array.
//            Loads A/B, clears the array, feeds skewed operands, drains, and
//            writes C back to memory O.
// Revision : 1.0 - initial release
// ============================================================================
module sys_array_sequencer #(
    parameter int N  = 4,
    parameter int DW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ap_start,
    output logic                ap_idle,
    output logic                ap_done,
    output logic                enA,
    output logic [31:0]         addrA_row,
    output logic [3:0]          addrA_col,
    input  logic [DW-1:0]       dataA_in,
    output logic                enB,
    output logic [31:0]         addrB_row,
    output logic [3:0]          addrB_col,
    input  logic [DW-1:0]       dataB_in,
    output logic                enO,
    output logic [31:0]         addrO_row,
    output logic [3:0]          addrO_col,
    output logic [DW-1:0]       dataO,
    output logic                sa_clear,
    output logic                sa_valid,
    output logic [N*DW-1:0]     sa_a,
    output logic [N*DW-1:0]     sa_b,
    input  logic [N*N*DW-1:0]   res_in
);

    localparam int c_NN    = N * N;
    localparam int c_IDX_W = (c_NN > 1) ? $clog2(c_NN) : 1;
    localparam int c_CNT_W = $clog2(c_NN + 3 * N + 1);

    localparam logic [c_CNT_W-1:0] c_LOAD_LAST  = c_CNT_W'(c_NN);
    localparam logic [c_CNT_W-1:0] c_READ_CNT   = c_CNT_W'(c_NN);
    localparam logic [c_CNT_W-1:0] c_FEED_LAST  = c_CNT_W'(3 * N - 3);
    localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(N - 1);
    localparam logic [c_CNT_W-1:0] c_WRITE_LAST = c_CNT_W'(c_NN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FEED  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t               r_state, w_stateNext;
    logic [c_CNT_W-1:0]   r_cnt, w_cntNext;
    logic [c_IDX_W-1:0]   w_idx;

    logic [DW-1:0]        r_bufA [c_NN];
    logic [DW-1:0]        r_bufB [c_NN];
    logic [DW-1:0]        w_bufAView [c_NN];
    logic [DW-1:0]        w_bufBView [c_NN];

    logic                 r_pend;
    logic [c_IDX_W-1:0]   r_pendIdx;
    logic [c_IDX_W-1:0]   r_rdIdx;

    logic                 r_idle, r_done, r_clear, r_valid, r_rd, r_wr;
    logic [31:0]          r_rdRow, r_wrRow;
    logic [3:0]           r_rdCol, r_wrCol;
    logic [DW-1:0]        r_dataO;
    logic [N*DW-1:0]      r_saA, r_saB;

    logic                 w_idleNext, w_doneNext, w_clearNext, w_validNext;
    logic                 w_rdNext, w_wrNext;
    logic [31:0]          w_row;
    logic [3:0]           w_col;
    logic [DW-1:0]        w_dataONext;
    logic [N*DW-1:0]      w_saANext, w_saBNext;

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt + 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_cntNext = '0;
                if (ap_start) w_stateNext = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_cntNext   = '0;
                w_stateNext = ST_LOAD;
            end
            ST_LOAD: if (r_cnt == c_LOAD_LAST) begin
                w_cntNext   = '0;
                w_stateNext = ST_FEED;
            end
            ST_FEED: if (r_cnt == c_FEED_LAST) begin
                w_cntNext   = '0;
                w_stateNext = ST_DRAIN;
            end
            ST_DRAIN: if (r_cnt == c_DRAIN_LAST) begin
                w_cntNext   = '0;
                w_stateNext = ST_WRITE;
            end
            ST_WRITE: if (r_cnt == c_WRITE_LAST) begin
                w_cntNext   = '0;
                w_stateNext = ST_DONE;
            end
            ST_DONE: begin
                w_cntNext   = '0;
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_cntNext   = '0;
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // The last read word lands on the same edge that registers the first
    // feed step, so the buffer view forwards the in-flight capture.
    always_comb begin
        for (int k = 0; k < c_NN; k++) begin
            w_bufAView[k] = r_bufA[k];
            w_bufBView[k] = r_bufB[k];
            if (r_pend && r_pendIdx == c_IDX_W'(k)) begin
                w_bufAView[k] = dataA_in;
                w_bufBView[k] = dataB_in;
            end
        end
    end

    // Outputs are computed for the upcoming state and registered on the edge.
    always_comb begin
        w_idleNext  = (w_stateNext == ST_IDLE);
        w_doneNext  = (w_stateNext == ST_DONE);
        w_clearNext = (w_stateNext == ST_CLEAR);
        w_validNext = (w_stateNext == ST_FEED);
        w_rdNext    = (w_stateNext == ST_LOAD) && (w_cntNext < c_READ_CNT);
        w_wrNext    = (w_stateNext == ST_WRITE);
        w_idx       = w_cntNext[c_IDX_W-1:0];
        w_row       = 32'(w_idx) / 32'(N);
        w_col       = 4'(32'(w_idx) % 32'(N));
        w_dataONext = '0;
        w_saANext   = '0;
        w_saBNext   = '0;
        for (int k = 0; k < c_NN; k++) begin
            if (w_wrNext && w_idx == c_IDX_W'(k))
                w_dataONext = res_in[k*DW +: DW];
        end
        for (int i = 0; i < N; i++) begin
            for (int d = 0; d < N; d++) begin
                if (w_validNext && w_cntNext == c_CNT_W'(i + d)) begin
                    w_saANext[i*DW +: DW] = w_bufAView[i*N + d];
                    w_saBNext[i*DW +: DW] = w_bufBView[d*N + i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pend    <= 1'b0;
            r_pendIdx <= '0;
            r_rdIdx   <= '0;
            r_idle    <= 1'b1;
            r_done    <= 1'b0;
            r_clear   <= 1'b0;
            r_valid   <= 1'b0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_rdRow   <= '0;
            r_rdCol   <= '0;
            r_wrRow   <= '0;
            r_wrCol   <= '0;
            r_dataO   <= '0;
            r_saA     <= '0;
            r_saB     <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_pend    <= r_rd;
            r_pendIdx <= r_rdIdx;
            r_rdIdx   <= w_rdNext ? w_idx : '0;
            r_idle    <= w_idleNext;
            r_done    <= w_doneNext;
            r_clear   <= w_clearNext;
            r_valid   <= w_validNext;
            r_rd      <= w_rdNext;
            r_wr      <= w_wrNext;
            r_rdRow   <= w_rdNext ? w_row : '0;
            r_rdCol   <= w_rdNext ? w_col : '0;
            r_wrRow   <= w_wrNext ? w_row : '0;
            r_wrCol   <= w_wrNext ? w_col : '0;
            r_dataO   <= w_dataONext;
            r_saA     <= w_saANext;
            r_saB     <= w_saBNext;
        end
    end

    // Operand buffers carry no reset: every run reloads them before use.
    always_ff @(posedge clk) begin
        for (int k = 0; k < c_NN; k++) begin
            if (r_pend && r_pendIdx == c_IDX_W'(k)) begin
                r_bufA[k] <= dataA_in;
                r_bufB[k] <= dataB_in;
            end
        end
    end

    assign ap_idle   = r_idle;
    assign ap_done   = r_done;
    assign enA       = r_rd;
    assign addrA_row = r_rdRow;
    assign addrA_col = r_rdCol;
    assign enB       = r_rd;
    assign addrB_row = r_rdRow;
    assign addrB_col = r_rdCol;
    assign enO       = r_wr;
    assign addrO_row = r_wrRow;
    assign addrO_col = r_wrCol;
    assign dataO     = r_dataO;
    assign sa_clear  = r_clear;
    assign sa_valid  = r_valid;
    assign sa_a      = r_saA;
    assign sa_b      = r_saB;

endmodule
`default_nettype wire

// File: tb/tb_sys_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_array_sequencer
// Brief    : Directed bench with behavioural PE array and A/B/O memories.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_array_sequencer;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int NN = N * N;
    localparam logic [DW-1:0] SENT = 16'hDEAD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ap_start = 1'b0;
    logic ap_idle, ap_done, enA, enB, enO, sa_clear, sa_valid;
    logic [31:0] addrA_row, addrB_row, addrO_row;
    logic [3:0]  addrA_col, addrB_col, addrO_col;
    logic [DW-1:0] dataA_in, dataB_in, dataO;
    logic [N*DW-1:0] sa_a, sa_b;
    logic [N*N*DW-1:0] res_in;

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    sys_array_sequencer #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
        .enA(enA), .addrA_row(addrA_row), .addrA_col(addrA_col), .dataA_in(dataA_in),
        .enB(enB), .addrB_row(addrB_row), .addrB_col(addrB_col), .dataB_in(dataB_in),
        .enO(enO), .addrO_row(addrO_row), .addrO_col(addrO_col), .dataO(dataO),
        .sa_clear(sa_clear), .sa_valid(sa_valid), .sa_a(sa_a), .sa_b(sa_b), .res_in(res_in)
    );

    logic [DW-1:0] memA [NN];
    logic [DW-1:0] memB [NN];
    logic [DW-1:0] memO [NN];
    logic [DW-1:0] expO [NN];
    logic          clrO = 1'b0;

    function automatic int flat(input logic [31:0] r, input logic [3:0] c);
        return int'(r) * N + int'(c);
    endfunction

    always @(posedge clk) begin
        if (enA && flat(addrA_row, addrA_col) < NN) dataA_in <= memA[flat(addrA_row, addrA_col)];
        if (enB && flat(addrB_row, addrB_col) < NN) dataB_in <= memB[flat(addrB_row, addrB_col)];
        if (clrO) begin
            for (int k = 0; k < NN; k++) memO[k] <= SENT;
        end else if (enO && flat(addrO_row, addrO_col) < NN) begin
            memO[flat(addrO_row, addrO_col)] <= dataO;
        end
    end

    // Output-stationary systolic array: A flows east, B flows south.
    logic [DW-1:0] peA [N][N];
    logic [DW-1:0] peB [N][N];
    logic [DW-1:0] acc [N][N];

    always @(posedge clk) begin : pe_model
        logic [DW-1:0] aIn, bIn;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                aIn = (c == 0) ? sa_a[r*DW +: DW] : peA[r][c-1];
                bIn = (r == 0) ? sa_b[c*DW +: DW] : peB[r-1][c];
                if (sa_clear) begin
                    peA[r][c] <= '0;
                    peB[r][c] <= '0;
                    acc[r][c] <= '0;
                end else begin
                    peA[r][c] <= aIn;
                    peB[r][c] <= bIn;
                    acc[r][c] <= acc[r][c] + aIn * bIn;
                end
            end
        end
    end

    always_comb begin
        res_in = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                res_in[(r*N+c)*DW +: DW] = acc[r][c];
    end

    int   rDoneCnt, rDone0, rDone1, rEnOCnt, rRdCnt, rValidCnt;
    int   rFirstEnA, rFirstValid, rFirstEnO, rClearAt;
    logic idleLog [200];

    task automatic compute_expected();
        logic [DW-1:0] s;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++) s = s + memA[i*N+k] * memB[k*N+j];
                expO[i*N+j] = s;
            end
    endtask

    task automatic clear_o();
        clrO = 1'b1;
        @(negedge clk);
        clrO = 1'b0;
    endtask

    // Start at edge E; iteration c observes the cycle following edge E+c-1.
    task automatic do_run(input int busyAt, input bit chain, input int rstAt, input int nCyc);
        rDoneCnt = 0; rDone0 = -1; rDone1 = -1; rEnOCnt = 0; rRdCnt = 0; rValidCnt = 0;
        rFirstEnA = -1; rFirstValid = -1; rFirstEnO = -1; rClearAt = -1;
        for (int c = 0; c < 200; c++) idleLog[c] = 1'b0;
        ap_start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= nCyc; c++) begin
            idleLog[c] = ap_idle;
            if (enA) begin rRdCnt++; if (rFirstEnA < 0) rFirstEnA = c; end
            if (sa_valid) begin rValidCnt++; if (rFirstValid < 0) rFirstValid = c; end
            if (enO) begin rEnOCnt++; if (rFirstEnO < 0) rFirstEnO = c; end
            if (sa_clear && rClearAt < 0) rClearAt = c;
            if (ap_done) begin
                if (rDoneCnt == 0) rDone0 = c;
                else if (rDoneCnt == 1) rDone1 = c;
                rDoneCnt++;
            end
            ap_start = (c == busyAt) || (chain && rDone0 > 0 && c <= rDone0 + 1);
            clrO     = chain && (c == rDone0);
            rst      = (c == rstAt) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        ap_start = 1'b0;
        clrO     = 1'b0;
        rst      = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ap_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nVec++;
            if (ap_idle !== 1'b1 || {ap_done, enA, enB, enO, sa_clear, sa_valid} !== 6'b0 ||
                {addrA_row, addrA_col, addrB_row, addrB_col, addrO_row, addrO_col} !== '0 ||
                {dataO, sa_a, sa_b} !== '0) begin
                nErr++;
                $display("FAIL reset[%0d]: got idle=%b done=%b enA=%b enB=%b enO=%b clr=%b vld=%b dataO=%h sa_a=%h sa_b=%h, want idle=1 and all others 0",
                         i, ap_idle, ap_done, enA, enB, enO, sa_clear, sa_valid, dataO, sa_a, sa_b);
            end
        end
        ap_start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        nVec++;
        if (ap_idle !== 1'b1) begin
            nErr++;
            $display("FAIL idle_after_reset: got %b, want 1", ap_idle);
        end
    endtask

    task automatic test_identity();
        for (int k = 0; k < NN; k++) begin
            memA[k] = (k / N == k % N) ? 16'd1 : 16'd0;
            memB[k] = 16'(k + 1);
        end
        clear_o();
        do_run(-1, 1'b0, -1, 60);
        nVec++; if (rDone0 != 49)     begin nErr++; $display("FAIL id_done_cycle: got %0d, want 49", rDone0); end
        nVec++; if (rDoneCnt != 1)    begin nErr++; $display("FAIL id_done_count: got %0d, want 1", rDoneCnt); end
        nVec++; if (rEnOCnt != 16)    begin nErr++; $display("FAIL id_enO_count: got %0d, want 16", rEnOCnt); end
        nVec++; if (rRdCnt != 16)     begin nErr++; $display("FAIL id_en_rd_count: got %0d, want 16", rRdCnt); end
        nVec++; if (rValidCnt != 10)  begin nErr++; $display("FAIL id_valid_count: got %0d, want 10", rValidCnt); end
        nVec++; if (rClearAt != 1)    begin nErr++; $display("FAIL id_clear_cycle: got %0d, want 1", rClearAt); end
        nVec++; if (rFirstEnA != 2)   begin nErr++; $display("FAIL id_first_enA: got %0d, want 2", rFirstEnA); end
        nVec++; if (rFirstValid != 19) begin nErr++; $display("FAIL id_first_valid: got %0d, want 19", rFirstValid); end
        nVec++; if (rFirstEnO != 33)  begin nErr++; $display("FAIL id_first_enO: got %0d, want 33", rFirstEnO); end
        nVec++; if (idleLog[1] !== 1'b0 || idleLog[50] !== 1'b1) begin
            nErr++; $display("FAIL id_idle: got c1=%b c50=%b, want 0 1", idleLog[1], idleLog[50]);
        end
        for (int k = 0; k < NN; k++) begin
            nVec++;
            if (memO[k] !== 16'(k + 1)) begin
                nErr++; $display("FAIL id_O[%0d]: got %0d, want %0d", k, memO[k], k + 1);
            end
        end
    endtask

    task automatic load_mixed();
        logic [DW-1:0] a [NN];
        logic [DW-1:0] b [NN];
        a = '{2, 10, 2, 0, 6, 6, 15, 7, 12, 13, 11, 9, 14, 2, 6, 7};
        b = '{6, 11, 7, 4, 10, 13, 15, 11, 14, 4, 13, 5, 2, 4, 15, 14};
        for (int k = 0; k < NN; k++) begin memA[k] = a[k]; memB[k] = b[k]; end
        compute_expected();
    endtask

    task automatic test_mixed();
        logic [DW-1:0] row0 [N];
        row0 = '{140, 160, 190, 128};
        load_mixed();
        clear_o();
        do_run(-1, 1'b0, -1, 60);
        for (int j = 0; j < N; j++) begin
            nVec++;
            if (memO[j] !== row0[j]) begin
                nErr++; $display("FAIL mix_row0[%0d]: got %0d, want %0d", j, memO[j], row0[j]);
            end
        end
        for (int k = 0; k < NN; k++) begin
            nVec++;
            if (memO[k] !== expO[k]) begin
                nErr++; $display("FAIL mix_O[%0d]: got %0d, want %0d", k, memO[k], expO[k]);
            end
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < NN; k++) begin memA[k] = 16'h0100; memB[k] = 16'h0100; end
        clear_o();
        do_run(-1, 1'b0, -1, 60);
        for (int k = 0; k < NN; k++) begin
            nVec++;
            if (memO[k] !== 16'h0000) begin
                nErr++; $display("FAIL wrap_O[%0d]: got %h, want 0000", k, memO[k]);
            end
        end
    endtask

    task automatic test_busy_start();
        load_mixed();
        clear_o();
        do_run(20, 1'b0, -1, 70);
        nVec++; if (rDoneCnt != 1) begin nErr++; $display("FAIL busy_done_count: got %0d, want 1", rDoneCnt); end
        nVec++; if (rDone0 != 49)  begin nErr++; $display("FAIL busy_done_cycle: got %0d, want 49", rDone0); end
        nVec++; if (rRdCnt != 16)  begin nErr++; $display("FAIL busy_rd_count: got %0d, want 16", rRdCnt); end
        for (int k = 0; k < NN; k++) begin
            nVec++;
            if (memO[k] !== expO[k]) begin
                nErr++; $display("FAIL busy_O[%0d]: got %0d, want %0d", k, memO[k], expO[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        load_mixed();
        clear_o();
        do_run(-1, 1'b1, -1, 110);
        nVec++; if (rDone0 != 49)   begin nErr++; $display("FAIL b2b_done0: got %0d, want 49", rDone0); end
        nVec++; if (rDone1 != 99)   begin nErr++; $display("FAIL b2b_done1: got %0d, want 99", rDone1); end
        nVec++; if (rDoneCnt != 2)  begin nErr++; $display("FAIL b2b_done_count: got %0d, want 2", rDoneCnt); end
        nVec++; if (rEnOCnt != 32)  begin nErr++; $display("FAIL b2b_enO_count: got %0d, want 32", rEnOCnt); end
        nVec++; if (idleLog[50] !== 1'b1 || idleLog[51] !== 1'b0) begin
            nErr++; $display("FAIL b2b_idle: got c50=%b c51=%b, want 1 0", idleLog[50], idleLog[51]);
        end
        for (int k = 0; k < NN; k++) begin
            nVec++;
            if (memO[k] !== expO[k]) begin
                nErr++; $display("FAIL b2b_O[%0d]: got %0d, want %0d", k, memO[k], expO[k]);
            end
        end
    endtask

    task automatic test_midrun_reset();
        for (int k = 0; k < NN; k++) begin
            memA[k] = 16'(3 * k + 1);
            memB[k] = 16'(16'hFFF0 + k);
        end
        compute_expected();
        clear_o();
        do_run(-1, 1'b0, 22, 60);
        nVec++; if (idleLog[23] !== 1'b1) begin nErr++; $display("FAIL rst_idle_next: got %b, want 1", idleLog[23]); end
        nVec++; if (rEnOCnt != 0)  begin nErr++; $display("FAIL rst_enO_count: got %0d, want 0", rEnOCnt); end
        nVec++; if (rDoneCnt != 0) begin nErr++; $display("FAIL rst_done_count: got %0d, want 0", rDoneCnt); end
        for (int k = 0; k < NN; k++) begin
            nVec++;
            if (memO[k] !== SENT) begin
                nErr++; $display("FAIL rst_O_untouched[%0d]: got %h, want %h", k, memO[k], SENT);
            end
        end
        do_run(-1, 1'b0, -1, 60);
        nVec++; if (rDone0 != 49) begin nErr++; $display("FAIL rerun_done_cycle: got %0d, want 49", rDone0); end
        for (int k = 0; k < NN; k++) begin
            nVec++;
            if (memO[k] !== expO[k]) begin
                nErr++; $display("FAIL rerun_O[%0d]: got %0d, want %0d", k, memO[k], expO[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_mixed();
        test_wrap();
        test_busy_start();
        test_back_to_back();
        test_midrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
